// File: rtl/sevenseg_reader_if.sv
// ============================================================================
//  Module      : sevenseg_reader_if
//  Description : Segment input, digit output handshake and status bundle
//                for sevenseg_reader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sevenseg_reader_if;
  logic [6:0] seg_in;
  logic       out_ready;
  logic [3:0] out_digit;
  logic       out_valid;
  logic       blank;
  logic       err;
  logic       overflow;
  logic [7:0] digit_count;
  logic [7:0] err_count;

  modport master (
    input  seg_in,
    input  out_ready,
    output out_digit,
    output out_valid,
    output blank,
    output err,
    output overflow,
    output digit_count,
    output err_count
  );

  modport slave (
    output seg_in,
    output out_ready,
    input  out_digit,
    input  out_valid,
    input  blank,
    input  err,
    input  overflow,
    input  digit_count,
    input  err_count
  );
endinterface

`default_nettype wire

// File: rtl/sevenseg_reader.sv
// ============================================================================
//  Module      : sevenseg_reader
//  Description : Synchronizes and debounces a 7-segment pattern, decodes it to
//                a hex digit and offers it on a valid/ready output register.
//                Optional macro SEVENSEG_READER_ERRCNT_EN enables err_count.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sevenseg_reader #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  sevenseg_reader_if.master        bus
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] sync1_q, sync1_d;
  logic [6:0] sync2_q, sync2_d;
  logic [6:0] cand_q, cand_d;
  logic [6:0] acc_q, acc_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] out_digit_q, out_digit_d;
  logic       out_valid_q, out_valid_d;
  logic       blank_q, blank_d;
  logic       err_q, err_d;
  logic       overflow_q, overflow_d;
  logic [7:0] digit_count_q, digit_count_d;

  logic       accept;
  logic       dec_hit;
  logic [3:0] dec_digit;

  always_comb begin
    dec_hit   = 1'b1;
    dec_digit = 4'h0;
    case (cand_q)
      7'h3F: dec_digit = 4'h0;
      7'h06: dec_digit = 4'h1;
      7'h5B: dec_digit = 4'h2;
      7'h4F: dec_digit = 4'h3;
      7'h66: dec_digit = 4'h4;
      7'h6D: dec_digit = 4'h5;
      7'h7D: dec_digit = 4'h6;
      7'h07: dec_digit = 4'h7;
      7'h7F: dec_digit = 4'h8;
      7'h6F: dec_digit = 4'h9;
      7'h77: dec_digit = 4'hA;
      7'h7C: dec_digit = 4'hB;
      7'h39: dec_digit = 4'hC;
      7'h5E: dec_digit = 4'hD;
      7'h79: dec_digit = 4'hE;
      7'h71: dec_digit = 4'hF;
      default: dec_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    sync1_d       = bus.seg_in;
    sync2_d       = sync1_q;
    cand_d        = cand_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    out_digit_d   = out_digit_q;
    out_valid_d   = out_valid_q;
    blank_d       = blank_q;
    err_d         = 1'b0;
    overflow_d    = overflow_q;
    digit_count_d = digit_count_q;
    accept        = 1'b0;

    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = 8'd0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end

    case (state_q)
      SETTLE: begin
        if ((sync2_q == cand_q) && (cnt_q == CNT_MAX)) begin
          state_d = LOCKED;
          // Only a pattern different from the last accepted one has any effect
          accept  = (cand_q != acc_q);
        end
      end
      LOCKED: begin
        if (sync2_q != cand_q) state_d = SETTLE;
      end
      default: state_d = SETTLE;
    endcase

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    if (accept) begin
      acc_d = cand_q;
      if (dec_hit) begin
        blank_d = 1'b0;
        if (!out_valid_q || bus.out_ready) begin
          out_digit_d   = dec_digit;
          out_valid_d   = 1'b1;
          digit_count_d = digit_count_q + 8'd1;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (cand_q == 7'h00) begin
        blank_d = 1'b1;
      end else begin
        err_d   = 1'b1;
        blank_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SETTLE;
      sync1_q       <= 7'h00;
      sync2_q       <= 7'h00;
      cand_q        <= 7'h00;
      acc_q         <= 7'h00;
      cnt_q         <= 8'd0;
      out_digit_q   <= 4'h0;
      out_valid_q   <= 1'b0;
      blank_q       <= 1'b1;
      err_q         <= 1'b0;
      overflow_q    <= 1'b0;
      digit_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      cand_q        <= cand_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      out_digit_q   <= out_digit_d;
      out_valid_q   <= out_valid_d;
      blank_q       <= blank_d;
      err_q         <= err_d;
      overflow_q    <= overflow_d;
      digit_count_q <= digit_count_d;
    end
  end

`ifdef SEVENSEG_READER_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (err_d && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count_q <= 8'd0;
    else     err_count_q <= err_count_d;
  end

  assign bus.err_count = err_count_q;
`else
  assign bus.err_count = 8'd0;
`endif

  assign bus.out_digit   = out_digit_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.blank       = blank_q;
  assign bus.err         = err_q;
  assign bus.overflow    = overflow_q;
  assign bus.digit_count = digit_count_q;

endmodule

`default_nettype wire

// File: tb/tb_sevenseg_reader.sv
// ============================================================================
//  Module      : tb_sevenseg_reader
//  Description : Directed self-checking bench for sevenseg_reader.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sevenseg_reader;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

`ifdef SEVENSEG_READER_ERRCNT_EN
  localparam logic [7:0] EXP_ERRCNT = 8'd1;
`else
  localparam logic [7:0] EXP_ERRCNT = 8'd0;
`endif

  always #5 clk = ~clk;

  sevenseg_reader_if bus ();

  sevenseg_reader #(.STABLE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.seg_in = 7'h00;
    bus.out_ready = 1'b0;
    tick(2);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus.out_valid); end
    total++; if (bus.out_digit !== 4'h0) begin bad++; $display("FAIL reset_digit got=%0h exp=0", bus.out_digit); end
    total++; if (bus.blank !== 1'b1) begin bad++; $display("FAIL reset_blank got=%0b exp=1", bus.blank); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", bus.err); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", bus.overflow); end
    total++; if (bus.digit_count !== 8'd0) begin bad++; $display("FAIL reset_dcount got=%0d exp=0", bus.digit_count); end
    total++; if (bus.err_count !== 8'd0) begin bad++; $display("FAIL reset_ecount got=%0d exp=0", bus.err_count); end
    rst = 1'b0;
  endtask

  // Pattern applied just before edge 1; digit must appear after edge 7
  task automatic test_latency();
    bus.seg_in = 7'h5B;
    bus.out_ready = 1'b1;
    tick(6);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL latency_early got=%0b exp=0", bus.out_valid); end
    tick(1);
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL latency_valid got=%0b exp=1", bus.out_valid); end
    total++; if (bus.out_digit !== 4'h2) begin bad++; $display("FAIL latency_digit got=%0h exp=2", bus.out_digit); end
    total++; if (bus.digit_count !== 8'd1) begin bad++; $display("FAIL latency_dcount got=%0d exp=1", bus.digit_count); end
    total++; if (bus.blank !== 1'b0) begin bad++; $display("FAIL latency_blank got=%0b exp=0", bus.blank); end
  endtask

  task automatic test_glitch();
    int seen_valid;
    int seen_err;
    seen_valid = 0;
    seen_err = 0;
    tick(1);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL consume_clear got=%0b exp=0", bus.out_valid); end
    bus.seg_in = 7'h06;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (bus.out_valid !== 1'b0) seen_valid++;
      if (bus.err !== 1'b0) seen_err++;
    end
    bus.seg_in = 7'h5B;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (bus.out_valid !== 1'b0) seen_valid++;
      if (bus.err !== 1'b0) seen_err++;
    end
    total++; if (seen_valid !== 0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0 cycles", seen_valid); end
    total++; if (seen_err !== 0) begin bad++; $display("FAIL glitch_err got=%0d exp=0 cycles", seen_err); end
    total++; if (bus.digit_count !== 8'd1) begin bad++; $display("FAIL glitch_dcount got=%0d exp=1", bus.digit_count); end
    // A different accepted pattern re-arms re-emission of 0x5B
    bus.seg_in = 7'h06;
    tick(7);
    total++; if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'h1) begin bad++; $display("FAIL reemit_one got=%0b/%0h exp=1/1", bus.out_valid, bus.out_digit); end
    tick(3);
    bus.seg_in = 7'h5B;
    tick(7);
    total++; if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'h2) begin bad++; $display("FAIL reemit_two got=%0b/%0h exp=1/2", bus.out_valid, bus.out_digit); end
    total++; if (bus.digit_count !== 8'd3) begin bad++; $display("FAIL reemit_dcount got=%0d exp=3", bus.digit_count); end
    tick(3);
  endtask

  task automatic test_overflow();
    int moved;
    moved = 0;
    bus.out_ready = 1'b0;
    bus.seg_in = 7'h00;
    do_reset();
    bus.seg_in = 7'h3F;
    tick(10);
    bus.seg_in = 7'h7F;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.out_digit !== 4'h0 || bus.out_valid !== 1'b1) moved++;
    end
    total++; if (moved !== 0) begin bad++; $display("FAIL ovf_hold got=%0d exp=0 cycles", moved); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", bus.overflow); end
    total++; if (bus.digit_count !== 8'd1) begin bad++; $display("FAIL ovf_dcount got=%0d exp=1", bus.digit_count); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    bus.seg_in = 7'h00;
    do_reset();
    bus.seg_in = 7'h3F;
    tick(10);
    bus.seg_in = 7'h07;
    tick(6);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'h7) begin bad++; $display("FAIL b2b_load got=%0b/%0h exp=1/7", bus.out_valid, bus.out_digit); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow got=%0b exp=0", bus.overflow); end
    total++; if (bus.digit_count !== 8'd2) begin bad++; $display("FAIL b2b_dcount got=%0d exp=2", bus.digit_count); end
  endtask

  task automatic test_err();
    int pulses;
    pulses = 0;
    bus.out_ready = 1'b1;
    bus.seg_in = 7'h00;
    do_reset();
    bus.seg_in = 7'h49;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.err === 1'b1) pulses++;
    end
    total++; if (pulses !== 1) begin bad++; $display("FAIL err_pulses got=%0d exp=1", pulses); end
    total++; if (bus.err_count !== EXP_ERRCNT) begin bad++; $display("FAIL err_count got=%0d exp=%0d", bus.err_count, EXP_ERRCNT); end
    total++; if (bus.out_valid !== 1'b0 || bus.blank !== 1'b0) begin bad++; $display("FAIL err_side got=%0b/%0b exp=0/0", bus.out_valid, bus.blank); end
  endtask

  task automatic test_blank();
    int errs;
    int loads;
    errs = 0;
    loads = 0;
    bus.out_ready = 1'b1;
    bus.seg_in = 7'h00;
    do_reset();
    bus.seg_in = 7'h71;
    tick(7);
    total++; if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'hF) begin bad++; $display("FAIL blank_digitf got=%0b/%0h exp=1/f", bus.out_valid, bus.out_digit); end
    tick(3);
    total++; if (bus.blank !== 1'b0) begin bad++; $display("FAIL blank_low got=%0b exp=0", bus.blank); end
    bus.seg_in = 7'h00;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (bus.err === 1'b1) errs++;
      if (bus.out_valid === 1'b1) loads++;
    end
    total++; if (bus.blank !== 1'b1) begin bad++; $display("FAIL blank_high got=%0b exp=1", bus.blank); end
    total++; if (errs !== 0 || loads !== 0) begin bad++; $display("FAIL blank_quiet got=err%0d/valid%0d exp=0/0", errs, loads); end
    total++; if (bus.digit_count !== 8'd1) begin bad++; $display("FAIL blank_dcount got=%0d exp=1", bus.digit_count); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.seg_in = 7'h00;
    do_reset();
    bus.seg_in = 7'h3F;
    tick(10);
    bus.seg_in = 7'h6D;
    tick(2);
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.digit_count !== 8'd0) begin bad++; $display("FAIL midrst_clear got=%0b/%0d exp=0/0", bus.out_valid, bus.digit_count); end
    total++; if (bus.blank !== 1'b1 || bus.out_digit !== 4'h0) begin bad++; $display("FAIL midrst_blank got=%0b/%0h exp=1/0", bus.blank, bus.out_digit); end
    tick(1);
    rst = 1'b0;
    tick(6);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_early got=%0b exp=0", bus.out_valid); end
    tick(1);
    total++; if (bus.out_valid !== 1'b1 || bus.out_digit !== 4'h5) begin bad++; $display("FAIL midrst_digit got=%0b/%0h exp=1/5", bus.out_valid, bus.out_digit); end
    total++; if (bus.digit_count !== 8'd1) begin bad++; $display("FAIL midrst_dcount got=%0d exp=1", bus.digit_count); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_overflow();
    test_back_to_back();
    test_err();
    test_blank();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
